ext_muldiv: RTL and testbench

- Parametrised multi-cycle RV32M coprocessor on the CPU extension port (extA/extB/extR/extStart/extDone/extFunc3).
- Successor to the multiply-only `mul` extension.
- Adds the full M-extension mode set selected by extFunc3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Adds a configurable operand width and a configurable number of bits retired per cycle.
- Handles divide-by-zero and signed overflow as early-exit fast paths.

---
 rtl/ext_muldiv_pkg.sv | 32 +++
 rtl/ext_muldiv_if.sv | 22 ++
 rtl/ext_muldiv_step.sv | 40 ++++
 rtl/ext_muldiv.sv | 162 ++++++++++++++++
 tb/tb_ext_muldiv.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_muldiv_pkg.sv
// ext_pkg: shared definitions for the ext_muldiv RV32M coprocessor.
//   - M-extension funct3 operation codes
//   - FSM state encoding
//   - helpers that report the signedness of each operand for a given funct3
package ext_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM.
  function automatic logic f_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM.
  function automatic logic f_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ext_muldiv_if.sv
// ext_muldiv_if: CPU extension-port bundle for the ext_muldiv coprocessor.
//   start  : request, sampled only while the coprocessor is idle
//   func3  : M-extension operation code, sampled with start
//   a, b   : operands rs1/rs2, sampled with start
//   r      : result, stable from done until the next accepted start
//   done   : single-cycle completion pulse
//   busy   : operation in flight
// master = CPU side, slave = coprocessor side.
interface ext_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] r;
  logic            done;
  logic            busy;

  modport master (output start, func3, a, b, input r, done, busy);
  modport slave  (input start, func3, a, b, output r, done, busy);
endinterface

// File: rtl/ext_muldiv_step.sv
// muldiv_step: one combinational radix-2 step shared by multiply and divide.
//   i_is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc    : multiply: running high product half / divide: partial remainder
//   i_lo     : multiply: multiplier shifting out (product low half shifting in)
//              divide:   dividend shifting out (quotient shifting in)
//   i_opnd   : multiply: multiplicand magnitude / divide: divisor magnitude
//   o_acc, o_lo : updated values after one step
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_acc, i_lo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, i_opnd});
    // When the trial subtraction succeeds the true difference is below the
    // divisor, so the modular XLEN-bit difference is exact.
    w_diff  = w_shift[XLEN-1:0] - i_opnd;
    if (i_is_div) begin
      o_acc = w_ge ? w_diff : w_shift[XLEN-1:0];
      o_lo  = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_acc = w_sum[XLEN:1];
      o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ext_muldiv.sv
// ext_muldiv: multi-cycle RV32M coprocessor (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ext_muldiv_if slave (start/func3/a/b in, r/done/busy out)
// Parameters:
//   XLEN           : operand/result width (even, >= 8)
//   BITS_PER_CYCLE : bits retired per CALC cycle (1, 2 or 4; divides XLEN)
// Operands are converted to magnitudes on acceptance, processed unsigned in
// CALC, and sign-corrected in FIX. Divide-by-zero and signed overflow skip
// CALC entirely.
module ext_muldiv
  import ext_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic         clk,
  input logic         rst,
  ext_muldiv_if.slave bus
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_fast_res;
  logic            r_fast;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_r;
  logic            r_done;
  logic            r_busy;

  // Acceptance-time decode of the live bus operands.
  logic            w_is_div;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_fast_res;

  always_comb begin
    w_is_div = bus.func3[2];
    w_a_neg  = f_a_signed(bus.func3) & bus.a[XLEN-1];
    w_b_neg  = f_b_signed(bus.func3) & bus.b[XLEN-1];
    w_mag_a  = w_a_neg ? -bus.a : bus.a;
    w_mag_b  = w_b_neg ? -bus.b : bus.b;
    w_div0   = w_is_div && (bus.b == '0);
    w_ovf    = ((bus.func3 == F3_DIV) || (bus.func3 == F3_REM)) &&
               (bus.a == MIN_INT) && (bus.b == '1);
    // func3[1] distinguishes REM/REMU from DIV/DIVU.
    if (w_div0) w_fast_res = bus.func3[1] ? bus.a : '1;
    else        w_fast_res = bus.func3[1] ? '0 : MIN_INT;
  end

  // Step chain: BITS_PER_CYCLE radix-2 steps per clock.
  logic [XLEN-1:0] w_acc [0:BITS_PER_CYCLE];
  logic [XLEN-1:0] w_lo  [0:BITS_PER_CYCLE];

  assign w_acc[0] = r_acc;
  assign w_lo[0]  = r_lo;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (r_f3[2]),
      .i_acc    (w_acc[g]),
      .i_lo     (w_lo[g]),
      .i_opnd   (r_opnd),
      .o_acc    (w_acc[g+1]),
      .o_lo     (w_lo[g+1])
    );
  end

  // Sign correction and result selection.
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  always_comb begin
    w_prod_s = r_neg_res ? -{r_acc, r_lo} : {r_acc, r_lo};
    w_quot   = r_neg_res ? -r_lo  : r_lo;
    w_rem    = r_neg_rem ? -r_acc : r_acc;
    w_result = '0;
    case (r_f3)
      F3_MUL:                         w_result = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   w_result = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                w_result = w_quot;
      default:                        w_result = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_f3       <= '0;
      r_acc      <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_fast_res <= '0;
      r_fast     <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_cnt      <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_f3       <= bus.func3;
            r_busy     <= 1'b1;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_acc      <= '0;
            r_fast_res <= w_fast_res;
            if (w_div0 || w_ovf) begin
              r_fast  <= 1'b1;
              r_state <= ST_FIX;
            end else begin
              r_fast  <= 1'b0;
              r_cnt   <= CW'(N);
              // Divide shifts the dividend through r_lo; multiply shifts the
              // multiplier (rs2) through r_lo and adds rs1.
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc[BITS_PER_CYCLE];
          r_lo  <= w_lo[BITS_PER_CYCLE];
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_r     <= r_fast ? r_fast_res : w_result;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.r    = r_r;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_ext_muldiv.sv
// Testbench for ext_muldiv: three instances (BITS_PER_CYCLE = 1, 2, 4) at
// XLEN=32, directed vectors with literal expectations, plus a latency/result
// model compared against every instance on every cycle.
module tb_ext_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ext_muldiv_if #(.XLEN(32)) ifc0 ();
  ext_muldiv_if #(.XLEN(32)) ifc1 ();
  ext_muldiv_if #(.XLEN(32)) ifc2 ();

  ext_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  ext_muldiv #(.XLEN(32), .BITS_PER_CYCLE(2)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1));
  ext_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut2 (.clk(clk), .rst(rst), .bus(ifc2));

  logic        st  [3];
  logic [2:0]  f3v [3];
  logic [31:0] av  [3];
  logic [31:0] bv  [3];
  logic [31:0] rr  [3];
  logic        dn  [3];
  logic        bz  [3];

  assign ifc0.start = st[0];  assign ifc0.func3 = f3v[0];
  assign ifc0.a     = av[0];  assign ifc0.b     = bv[0];
  assign ifc1.start = st[1];  assign ifc1.func3 = f3v[1];
  assign ifc1.a     = av[1];  assign ifc1.b     = bv[1];
  assign ifc2.start = st[2];  assign ifc2.func3 = f3v[2];
  assign ifc2.a     = av[2];  assign ifc2.b     = bv[2];
  assign rr[0] = ifc0.r;  assign dn[0] = ifc0.done;  assign bz[0] = ifc0.busy;
  assign rr[1] = ifc1.r;  assign dn[1] = ifc1.done;  assign bz[1] = ifc1.busy;
  assign rr[2] = ifc2.r;  assign dn[2] = ifc2.done;  assign bz[2] = ifc2.busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    logic [63:0]     p;
    case (f)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: an accepted request completes after a fixed number of edges
  // (1 for fast paths, XLEN/BPC+1 otherwise); busy covers the wait.
  logic [31:0] m_r    [3];
  logic [31:0] m_res  [3];
  int          m_cnt  [3];
  logic        m_done [3];
  logic        m_busy [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        m_r[u] <= '0; m_res[u] <= '0; m_cnt[u] <= 0; m_done[u] <= 1'b0; m_busy[u] <= 1'b0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (m_cnt[u] == 0) begin
          m_done[u] <= 1'b0;
          if (st[u]) begin
            m_res[u]  <= ref_op(f3v[u], av[u], bv[u]);
            m_cnt[u]  <= ref_fast(f3v[u], av[u], bv[u]) ? 1 : (32 >> u) + 1;
            m_busy[u] <= 1'b1;
          end
        end else begin
          m_cnt[u] <= m_cnt[u] - 1;
          if (m_cnt[u] == 1) begin
            m_done[u] <= 1'b1;
            m_r[u]    <= m_res[u];
            m_busy[u] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("model_u%0d_done@%0d", u, cyc), 32'(dn[u]), 32'(m_done[u]));
        chk($sformatf("model_u%0d_busy@%0d", u, cyc), 32'(bz[u]), 32'(m_busy[u]));
        chk($sformatf("model_u%0d_r@%0d", u, cyc), rr[u], m_r[u]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input int u, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int c0);
    c0 = cyc;
    st[u] = 1'b1; f3v[u] = f; av[u] = a; bv[u] = b;
    @(posedge clk); #1;
    st[u] = 1'b0;
    f3v[u] = 3'($urandom); av[u] = $urandom; bv[u] = $urandom;
  endtask

  task automatic wait_done(input int u, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dn[u] === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic do_op(input int u, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int elat, input string nm);
    int c0; bit ok;
    @(posedge clk); #1;
    launch(u, f, a, b, c0);
    wait_done(u, ok);
    chk({nm, "_seen_done"}, 32'(ok), 32'd1);
    chk({nm, "_r"}, rr[u], er);
    chk({nm, "_lat"}, 32'(cyc - c0), 32'(elat));
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs [14];
  vec_t vwid [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  c0;
    bit  ok;
    int  spurious;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7x-3"};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, "mulh_min2"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max2"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_m1"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "div_-7/2"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "rem_-7/2"};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34, "divu_100/7"};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34, "remu_100/7"};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  "div_5/0"};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2,  "rem_5/0"};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  "div_ovf"};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2,  "rem_ovf"};
    vecs[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  "divu_5/0"};
    vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         2,  "remu_9/0"};

    vwid[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7x-3"};
    vwid[1]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, "div_-7/2"};
    vwid[2]  = '{3'd5, 32'd100,        32'd7,         32'd14,        0, "divu_100/7"};
    vwid[3]  = '{3'd7, 32'd100,        32'd7,         32'd2,         0, "remu_100/7"};

    for (int u = 0; u < 3; u++) begin
      st[u] = 1'b0; f3v[u] = '0; av[u] = '0; bv[u] = '0;
    end

    // Literal pins on the reference arithmetic itself.
    chk("pin_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("pin_mulh",   ref_op(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_div",    ref_op(3'd4, 32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFD);
    chk("pin_rem",    ref_op(3'd6, 32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset_u%0d_r", u),    rr[u],       32'h0);
      chk($sformatf("reset_u%0d_done", u), 32'(dn[u]),  32'h0);
      chk($sformatf("reset_u%0d_busy", u), 32'(bz[u]),  32'h0);
    end
    chk_en = 1'b1;

    foreach (vecs[i])
      do_op(0, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, {"bpc1_", vecs[i].nm});

    // Start while busy is ignored; the first result is delivered unchanged.
    @(posedge clk); #1;
    launch(0, 3'd5, 32'd1000, 32'd7, c0);
    repeat (5) @(posedge clk);
    #1;
    st[0] = 1'b1; f3v[0] = 3'd0; av[0] = 32'd9; bv[0] = 32'd9;
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_done(0, ok);
    chk("busy_ign_seen_done", 32'(ok), 32'd1);
    chk("busy_ign_r",   rr[0], 32'd142);
    chk("busy_ign_lat", 32'(cyc - c0), 32'd34);

    // Start in the done cycle is accepted.
    @(posedge clk); #1;
    launch(0, 3'd0, 32'd5, 32'd6, c0);
    wait_done(0, ok);
    chk("b2b_first_r", rr[0], 32'd30);
    launch(0, 3'd5, 32'd100, 32'd7, c0);
    wait_done(0, ok);
    chk("b2b_second_seen_done", 32'(ok), 32'd1);
    chk("b2b_second_r",   rr[0], 32'd14);
    chk("b2b_second_lat", 32'(cyc - c0), 32'd34);

    // Asynchronous reset mid-operation.
    @(posedge clk); #1;
    launch(0, 3'd0, 32'd123, 32'd456, c0);
    while (cyc < c0 + 10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_r",    rr[0],      32'h0);
    chk("async_rst_done", 32'(dn[0]), 32'h0);
    chk("async_rst_busy", 32'(bz[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn[0] === 1'b1) spurious++;
    end
    chk("post_rst_spurious_done", 32'(spurious), 32'd0);
    do_op(0, 3'd0, 32'd3, 32'd4, 32'd12, 34, "post_rst_mul_3x4");

    // Wider radix instances.
    for (int u = 1; u < 3; u++) begin
      foreach (vwid[i])
        do_op(u, vwid[i].f, vwid[i].a, vwid[i].b, vwid[i].r, (32 >> u) + 2,
              $sformatf("bpc%0d_%s", 1 << u, vwid[i].nm));
      do_op(u, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, $sformatf("bpc%0d_div_5/0", 1 << u));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
